// File: rtl/dct_in_butterfly.sv
// DCT input butterfly: collects a 16-sample block serially, then produces the
// eight half-scaled difference terms (odd path) and eight half-scaled sum
// terms (even path), and sequences the downstream stages with cnt_clk.
module dct_in_butterfly #(
  parameter int DATA_W  = 24,
  parameter int CNT_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DATA_W-1:0] a0,
  output logic [DATA_W-1:0] a1,
  output logic [DATA_W-1:0] a2,
  output logic [DATA_W-1:0] a3,
  output logic [DATA_W-1:0] a4,
  output logic [DATA_W-1:0] a5,
  output logic [DATA_W-1:0] a6,
  output logic [DATA_W-1:0] a7,
  output logic [DATA_W-1:0] e0,
  output logic [DATA_W-1:0] e1,
  output logic [DATA_W-1:0] e2,
  output logic [DATA_W-1:0] e3,
  output logic [DATA_W-1:0] e4,
  output logic [DATA_W-1:0] e5,
  output logic [DATA_W-1:0] e6,
  output logic [DATA_W-1:0] e7,
  output logic [3:0]        cnt_clk,
  output logic              out_valid
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(CNT_MAX);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        wr_idx;
  logic [3:0]        cnt_r;
  logic              out_valid_r;
  logic              accept;
  logic [DATA_W-1:0] x_buf [16];
  logic [DATA_W-1:0] a_r   [8];
  logic [DATA_W-1:0] e_r   [8];
  logic [DATA_W:0]   sum_w [8];
  logic [DATA_W:0]   dif_w [8];

  assign din_ready = (state == FILL);
  assign accept    = din_valid && (state == FILL);
  assign cnt_clk   = cnt_r;
  assign out_valid = out_valid_r;

  assign a0 = a_r[0];
  assign a1 = a_r[1];
  assign a2 = a_r[2];
  assign a3 = a_r[3];
  assign a4 = a_r[4];
  assign a5 = a_r[5];
  assign a6 = a_r[6];
  assign a7 = a_r[7];
  assign e0 = e_r[0];
  assign e1 = e_r[1];
  assign e2 = e_r[2];
  assign e3 = e_r[3];
  assign e4 = e_r[4];
  assign e5 = e_r[5];
  assign e6 = e_r[6];
  assign e7 = e_r[7];

  // State register; reset abandons any partial or in-flight block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Next state: fill until x[15] is taken, one compute cycle, then emit steps
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (accept && (wr_idx == 4'd15)) state_nxt = CALC;
      CALC:    state_nxt = EMIT;
      EMIT:    if (cnt_r == CNT_LAST) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Sample buffer; the 4-bit write index wraps to 0 after x[15] on its own
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= '0;
      for (int i = 0; i < 16; i++) x_buf[i] <= '0;
    end else if (accept) begin
      x_buf[wr_idx] <= din;
      wr_idx        <= wr_idx + 4'd1;
    end
  end

  // Mirrored pair sums/differences, one bit wider so they cannot overflow
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      sum_w[i] = {x_buf[i][DATA_W-1], x_buf[i]} + {x_buf[15-i][DATA_W-1], x_buf[15-i]};
      dif_w[i] = {x_buf[i][DATA_W-1], x_buf[i]} - {x_buf[15-i][DATA_W-1], x_buf[15-i]};
    end
  end

  // Output terms load only in CALC and hold until the next block's CALC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        a_r[i] <= '0;
        e_r[i] <= '0;
      end
    end else if (state == CALC) begin
      for (int i = 0; i < 8; i++) begin
        a_r[i] <= dif_w[i][DATA_W:1];
        e_r[i] <= sum_w[i][DATA_W:1];
      end
    end
  end

  // Step counter and valid flag for the downstream odd/even stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
    end else if (state == CALC) begin
      cnt_r       <= 4'd1;
      out_valid_r <= 1'b1;
    end else if (state == EMIT) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r       <= '0;
        out_valid_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_dct_in_butterfly.sv
// Testbench for dct_in_butterfly: a CNT_MAX=3 instance for most scenarios and a
// CNT_MAX=15 instance for the back-to-back timing; both share clk/rst/din.
module tb_dct_in_butterfly;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_valid;

  logic          rdy3, ov3, rdy15, ov15;
  logic [3:0]    cnt3, cnt15;
  logic [DW-1:0] oa3 [8];
  logic [DW-1:0] oe3 [8];
  logic [DW-1:0] oa15 [8];
  logic [DW-1:0] oe15 [8];

  logic [DW-1:0] exp_a [8];
  logic [DW-1:0] exp_e [8];
  logic [DW-1:0] blk [16];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dct_in_butterfly #(.DATA_W(DW), .CNT_MAX(3)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy3),
    .a0(oa3[0]), .a1(oa3[1]), .a2(oa3[2]), .a3(oa3[3]),
    .a4(oa3[4]), .a5(oa3[5]), .a6(oa3[6]), .a7(oa3[7]),
    .e0(oe3[0]), .e1(oe3[1]), .e2(oe3[2]), .e3(oe3[3]),
    .e4(oe3[4]), .e5(oe3[5]), .e6(oe3[6]), .e7(oe3[7]),
    .cnt_clk(cnt3), .out_valid(ov3)
  );

  dct_in_butterfly #(.DATA_W(DW), .CNT_MAX(15)) dut15 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy15),
    .a0(oa15[0]), .a1(oa15[1]), .a2(oa15[2]), .a3(oa15[3]),
    .a4(oa15[4]), .a5(oa15[5]), .a6(oa15[6]), .a7(oa15[7]),
    .e0(oe15[0]), .e1(oe15[1]), .e2(oe15[2]), .e3(oe15[3]),
    .e4(oe15[4]), .e5(oe15[5]), .e6(oe15[6]), .e7(oe15[7]),
    .cnt_clk(cnt15), .out_valid(ov15)
  );

  // Reference: floor-halved mirrored sums/differences in plain integer maths
  function automatic void build_model();
    longint xi, xj;
    for (int i = 0; i < 8; i++) begin
      xi = longint'($signed(blk[i]));
      xj = longint'($signed(blk[15-i]));
      exp_a[i] = DW'((xi - xj) >>> 1);
      exp_e[i] = DW'((xi + xj) >>> 1);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present the 16 samples of blk in order with random idle gaps
  task automatic feed_block(input int max_gap);
    for (int i = 0; i < 16; i++) begin
      int gap;
      gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      repeat (gap) begin
        din_valid = 1'b0;
        din       = DW'($urandom);
        step();
      end
      din       = blk[i];
      din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = '0; din_valid = 1'b0;
    #3;
    n_checks++;
    if (cnt3 !== 4'd0 || ov3 !== 1'b0 || rdy3 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: got cnt=%0d ov=%b rdy=%b expected 0 0 1", cnt3, ov3, rdy3);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (oa3[i] !== '0 || oe3[i] !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset_out%0d: got a=%h e=%h expected 0 0", i, oa3[i], oe3[i]);
      end
    end
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;
    step();
    n_checks++;
    if (rdy3 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ready_after_reset: got %b expected 1", rdy3);
    end
  endtask

  task automatic test_constant();
    for (int i = 0; i < 16; i++) blk[i] = 24'h000100;
    feed_block(0);
    n_checks++;
    if (rdy3 !== 1'b0 || ov3 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL const_calc: got rdy=%b ov=%b expected 0 0", rdy3, ov3);
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      n_checks++;
      if (ov3 !== 1'b1 || cnt3 !== 4'(k)) begin
        n_fail++;
        $display("[TB] FAIL const_step%0d: got ov=%b cnt=%0d expected 1 %0d", k, ov3, cnt3, k);
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (oa3[i] !== 24'h000000 || oe3[i] !== 24'h000100) begin
        n_fail++;
        $display("[TB] FAIL const_out%0d: got a=%h e=%h expected 000000 000100", i, oa3[i], oe3[i]);
      end
    end
    step();
    n_checks++;
    if (ov3 !== 1'b0 || cnt3 !== 4'd0 || rdy3 !== 1'b1 || oe3[0] !== 24'h000100) begin
      n_fail++;
      $display("[TB] FAIL const_end: got ov=%b cnt=%0d rdy=%b e0=%h expected 0 0 1 000100",
               ov3, cnt3, rdy3, oe3[0]);
    end
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 16; i++) blk[i] = DW'(i);
    feed_block(2);
    step();
    for (int i = 0; i < 8; i++) begin
      logic [DW-1:0] ea;
      ea = 24'hFFFFF8 + DW'(i);
      n_checks++;
      if (oa3[i] !== ea || oe3[i] !== 24'h000007) begin
        n_fail++;
        $display("[TB] FAIL ramp_out%0d: got a=%h e=%h expected %h 000007", i, oa3[i], oe3[i], ea);
      end
    end
    repeat (3) step();
  endtask

  task automatic test_extremes();
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = 24'h7FFFFF;
    blk[15] = 24'h800000;
    feed_block(1);
    step();
    n_checks++;
    if (oa3[0] !== 24'h7FFFFF || oe3[0] !== 24'hFFFFFF) begin
      n_fail++;
      $display("[TB] FAIL extreme_pair0: got a0=%h e0=%h expected 7fffff ffffff", oa3[0], oe3[0]);
    end
    for (int i = 1; i < 8; i++) begin
      n_checks++;
      if (oa3[i] !== '0 || oe3[i] !== '0) begin
        n_fail++;
        $display("[TB] FAIL extreme_out%0d: got a=%h e=%h expected 0 0", i, oa3[i], oe3[i]);
      end
    end
    repeat (3) step();
  endtask

  task automatic test_random_gaps();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) blk[i] = DW'($urandom);
      build_model();
      feed_block(3);
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (rdy3 !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL rand_busy%0d_%0d: got rdy=%b expected 0", b, k, rdy3);
        end
        din_valid = 1'b1;
        din       = DW'($urandom);
        step();
        if (k == 0) begin
          for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (oa3[i] !== exp_a[i] || oe3[i] !== exp_e[i] || ov3 !== 1'b1) begin
              n_fail++;
              $display("[TB] FAIL rand%0d_out%0d: got a=%h e=%h ov=%b expected %h %h 1",
                       b, i, oa3[i], oe3[i], ov3, exp_a[i], exp_e[i]);
            end
          end
        end
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic test_reset_in_emit();
    for (int i = 0; i < 16; i++) blk[i] = DW'($urandom);
    feed_block(0);
    step(); step();
    n_checks++;
    if (cnt3 !== 4'd2) begin
      n_fail++;
      $display("[TB] FAIL emit_pre_reset: got cnt=%0d expected 2", cnt3);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (cnt3 !== 4'd0 || ov3 !== 1'b0 || rdy3 !== 1'b1 || oa3[3] !== '0 || oe3[5] !== '0) begin
      n_fail++;
      $display("[TB] FAIL emit_reset: got cnt=%0d ov=%b rdy=%b a3=%h e5=%h expected 0 0 1 0 0",
               cnt3, ov3, rdy3, oa3[3], oe3[5]);
    end
    @(posedge clk); #3 rst = 1'b0;
    // partial block, then a reset mid-fill that must discard it
    for (int i = 0; i < 16; i++) blk[i] = DW'($urandom);
    for (int i = 0; i < 5; i++) begin
      din = blk[i]; din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #3 rst = 1'b0;
    for (int i = 0; i < 16; i++) blk[i] = DW'($urandom);
    build_model();
    feed_block(2);
    step();
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (oa3[i] !== exp_a[i] || oe3[i] !== exp_e[i]) begin
        n_fail++;
        $display("[TB] FAIL post_reset_out%0d: got a=%h e=%h expected %h %h",
                 i, oa3[i], oe3[i], exp_a[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    #2 rst = 1'b1;
    @(posedge clk); #3 rst = 1'b0;
    for (int b = 0; b < 2; b++) begin
      int low;
      for (int i = 0; i < 16; i++) blk[i] = DW'($urandom);
      build_model();
      feed_block(0);
      low = 0;
      while (rdy15 === 1'b0 && low < 40) begin
        n_checks++;
        if (cnt15 !== 4'(low) || ov15 !== (low != 0)) begin
          n_fail++;
          $display("[TB] FAIL b2b%0d_cyc%0d: got cnt=%0d ov=%b expected %0d %b",
                   b, low, cnt15, ov15, low, low != 0);
        end
        if (low == 1) begin
          for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (oa15[i] !== exp_a[i] || oe15[i] !== exp_e[i]) begin
              n_fail++;
              $display("[TB] FAIL b2b%0d_out%0d: got a=%h e=%h expected %h %h",
                       b, i, oa15[i], oe15[i], exp_a[i], exp_e[i]);
            end
          end
        end
        din_valid = 1'b1;
        din       = DW'($urandom);
        step();
        low++;
      end
      n_checks++;
      if (low != 16 || cnt15 !== 4'd0 || ov15 !== 1'b0 || oa15[7] !== exp_a[7]) begin
        n_fail++;
        $display("[TB] FAIL b2b%0d_busy: got low=%0d cnt=%0d ov=%b a7=%h expected 16 0 0 %h",
                 b, low, cnt15, ov15, oa15[7], exp_a[7]);
      end
    end
    din_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_extremes();
    test_random_gaps();
    test_reset_in_emit();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
